// File: rtl/traffic_light_pkg.sv
// Shared constants, converter state type and helpers for the traffic countdown display.
package traffic_light_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    C_IDLE,
    C_SHIFT,
    C_LOAD
  } conv_state_t;

  function automatic int unsigned cycles_from_ns(input int unsigned ns,
                                                 input int unsigned period_ns);
    return ns / period_ns;
  endfunction

  function automatic logic [6:0] seg_of_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction: every BCD digit of 5 or more gets +3 before the shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int unsigned i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, re-converts only when the input changes.
module bin2bcd_seq
  import traffic_light_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic [CNT_WIDTH-1:0] bin,
  output logic [3:0]           tens,
  output logic [3:0]           units
);

  conv_state_t          state, state_nxt;
  logic [CNT_WIDTH-1:0] bin_sh;
  logic [CNT_WIDTH-1:0] bin_lat;
  logic [CNT_WIDTH-1:0] last_val;
  logic [11:0]          bcd_sh;
  logic [2:0]           shift_cnt;
  logic                 start;
  logic                 shift_done;

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) state <= C_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE:  if (start) state_nxt = C_SHIFT;
      C_SHIFT: if (shift_done) state_nxt = C_LOAD;
      C_LOAD:  state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    start      = (state == C_IDLE) && (bin != last_val);
    shift_done = (state == C_SHIFT) && (shift_cnt == 3'(CNT_WIDTH - 1));
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      bin_sh    <= '0;
      bin_lat   <= '0;
      last_val  <= '0;
      bcd_sh    <= '0;
      shift_cnt <= '0;
      tens      <= '0;
      units     <= '0;
    end else begin
      case (state)
        C_IDLE: begin
          if (start) begin
            bin_sh    <= bin;
            bin_lat   <= bin;
            bcd_sh    <= '0;
            shift_cnt <= '0;
          end
        end
        C_SHIFT: begin
          {bcd_sh, bin_sh} <= {dd_adjust(bcd_sh), bin_sh} << 1;
          shift_cnt        <= shift_cnt + 3'd1;
        end
        C_LOAD: begin
          last_val <= bin_lat;
          // A non-zero hundreds digit only occurs above 99; pin the display at 99.
          if (bcd_sh[11:8] != 4'd0) begin
            tens  <= 4'd9;
            units <= 4'd9;
          end else begin
            tens  <= bcd_sh[7:4];
            units <= bcd_sh[3:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/traffic_countdown_display.sv
// Two-digit multiplexed countdown display with leading-zero blanking, yellow blink and error dash.
module traffic_countdown_display
  import traffic_light_pkg::*;
#(
  parameter int unsigned CL_PERIOD_TIME = 100,
  parameter int unsigned CNT_WIDTH      = 5,
  parameter int unsigned SCAN_TIME_NS   = 1000000,
  parameter int unsigned BLINK_TIME_NS  = 500000000
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 en,
  input  logic                 red_light,
  input  logic                 yellow_light,
  input  logic                 green_light,
  input  logic [CNT_WIDTH-1:0] cnt_out_num,
  output logic [6:0]           seg,
  output logic [1:0]           dig_sel,
  output logic                 light_err
);

  localparam int unsigned SCAN_CYC  = cycles_from_ns(SCAN_TIME_NS, CL_PERIOD_TIME);
  localparam int unsigned BLINK_CYC = cycles_from_ns(BLINK_TIME_NS, CL_PERIOD_TIME);
  localparam int unsigned SCAN_W    = $clog2(SCAN_CYC);
  localparam int unsigned BLINK_W   = $clog2(BLINK_CYC);

  logic [SCAN_W-1:0]  scan_cnt;
  logic               slot_tens;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [3:0]         tens;
  logic [3:0]         units;
  logic               lights_ok;
  logic [6:0]         seg_nxt;

  bin2bcd_seq #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_bin2bcd (
    .clk  (clk),
    .rstb (rstb),
    .bin  (cnt_out_num),
    .tens (tens),
    .units(units)
  );

  always_comb begin
    lights_ok = {red_light, yellow_light, green_light} inside {3'b100, 3'b010, 3'b001};
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) light_err <= 1'b0;
    else      light_err <= ~lights_ok;
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      scan_cnt  <= '0;
      slot_tens <= 1'b0;
    end else if (!en) begin
      scan_cnt  <= '0;
      slot_tens <= 1'b0;
    end else if (scan_cnt == SCAN_W'(SCAN_CYC - 1)) begin
      scan_cnt  <= '0;
      slot_tens <= ~slot_tens;
    end else begin
      scan_cnt  <= scan_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!en || !yellow_light || light_err) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BLINK_W'(BLINK_CYC - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Raw yellow_light gates the off phase so dropping yellow restores digits on the next edge.
  always_comb begin
    seg_nxt = SEG_BLANK;
    if (light_err)                       seg_nxt = SEG_DASH;
    else if (yellow_light && !blink_on)  seg_nxt = SEG_BLANK;
    else if (slot_tens)                  seg_nxt = (tens == 4'd0) ? SEG_BLANK : seg_of_digit(tens);
    else                                 seg_nxt = seg_of_digit(units);
  end

  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      seg     <= '0;
      dig_sel <= '0;
    end else if (!en) begin
      seg     <= '0;
      dig_sel <= '0;
    end else begin
      seg     <= seg_nxt;
      dig_sel <= slot_tens ? 2'b10 : 2'b01;
    end
  end

endmodule
